// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - receive-word handshake bundle between the UART receiver and its consumer
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 rx_done;
    logic                 parity_error;
    logic                 framing_error;
    logic                 overrun;

    // Receiver side: owns the word, its flags and the commit pulse.
    modport master (
        output data_out,
        output data_valid,
        output rx_done,
        output parity_error,
        output framing_error,
        output overrun,
        input  data_ready
    );

    // Consumer side: reads the word and acknowledges it with data_ready.
    modport slave (
        input  data_out,
        input  data_valid,
        input  rx_done,
        input  parity_error,
        input  framing_error,
        input  overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with parity, framing and overrun flags
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              enable,
    input  logic              bit_rx,
    output logic              busy,
    uart_rx_param_if.master   rx_if
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0] IDX_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] IDX_LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic ODD_PARITY = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 ovr_q, ovr_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 rx_s;
    logic                 commit;
    logic                 ferr_now;

    assign rx_s = sync2_q;

    // Next-state logic: synchroniser, bit-timing FSM, commit and handshake.
    always_comb begin
        state_d    = state_q;
        sync1_d    = bit_rx;
        sync2_d    = sync1_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = ovr_q;
        done_d     = 1'b0;
        commit     = 1'b0;
        ferr_now   = ferr_q | ~rx_s;

        case (state_q)
            S_IDLE: begin
                if (enable && !rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (cnt_q == CNT_MID) begin
                        if (!rx_s) begin
                            state_d = S_DATA;
                            cnt_d   = '0;
                            idx_d   = '0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                        end else begin
                            // Start bit was gone by mid-bit: treat as noise.
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_LAST_DATA) begin
                            idx_d   = '0;
                            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        perr_d  = ((^shift_q) ^ rx_s) != ODD_PARITY;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        ferr_d = ferr_now;
                        if (idx_q == IDX_LAST_STOP) begin
                            commit  = 1'b1;
                            // A low stop bit may be a break; wait for idle before rearming.
                            state_d = ferr_now ? S_WAIT_HIGH : S_IDLE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disarming abandons any partial frame without reporting it.
        if (!enable && state_q != S_IDLE) begin
            state_d = S_IDLE;
            commit  = 1'b0;
        end

        if (commit) begin
            done_d = 1'b1;
            if (!valid_q || rx_if.data_ready) begin
                data_d     = shift_q;
                perr_out_d = perr_d;
                ferr_out_d = ferr_now;
                valid_d    = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_if.data_ready) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_if.data_out      = data_q;
    assign rx_if.data_valid    = valid_q;
    assign rx_if.rx_done       = done_q;
    assign rx_if.parity_error  = perr_out_q;
    assign rx_if.framing_error = ferr_out_q;
    assign rx_if.overrun       = ovr_q;
    assign busy                = busy_q;
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8-bit receive path used by the receive instruction. Samples the serial line with an oversampling tick, checks start, parity and stop bits, and presents each received word on a valid/ready interface to the control unit and register-file write path. Adds configurable data width, oversampling ratio, parity and stop bits; start-glitch rejection; error flags; and overrun detection.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
OVERSAMPLE, 16, ticks per bit period (even, >=4)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked (1 or 2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-clock-wide oversample enable, OVERSAMPLE pulses per bit
enable  in  1  receive armed (driven while the receive instruction is executing)
bit_rx  in  1  asynchronous serial input, idle high
data_out  out  DATA_BITS  received word, LSB = first data bit received
data_valid  out  1  data_out holds an unconsumed word
data_ready  in  1  consumer accepts the word when data_valid=1
rx_done  out  1  one-clock pulse when a frame commits (releases the paused PC)
parity_error  out  1  parity mismatch for the word in data_out
framing_error  out  1  a stop bit was sampled low for the word in data_out
overrun  out  1  sticky: a frame completed while data_valid=1 and was dropped
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; data_out 0; both synchroniser flops 1; FSM in IDLE; counters 0.
- bit_rx passes through a 2-flop synchroniser. All sampling uses the synchronised value, adding 2 clocks of latency.
- FSM states are IDLE, START, DATA, PARITY, STOP and WAIT_HIGH. Counters advance only on clocks with tick=1.
- IDLE: when enable=1 and the synchronised line is 0, go to START with tick_cnt=0.
- START: on the tick where tick_cnt reaches OVERSAMPLE/2-1 (the mid-bit point), sample the line.
  - Line 0: go to DATA, tick_cnt=0, bit_idx=0.
  - Line 1: glitch; return to IDLE with no output.
- DATA: on each tick where tick_cnt reaches OVERSAMPLE-1, sample, then tick_cnt=0.
  - Shift right with the new bit inserted at the MSB.
  - Increment bit_idx.
  - After DATA_BITS samples, go to PARITY if PARITY!=0, else STOP.
- PARITY: sample at the same spacing. perr = XOR(data, sampled bit) != (PARITY==1 ? 1 : 0). Then go to STOP.
- STOP: sample STOP_BITS bits at the same spacing. ferr = any stop sample is 0.
- Commit happens on the clock of the last stop sample:
  - If data_valid=0, or data_valid=1 and data_ready=1 in that same cycle: data_out, parity_error and framing_error are loaded; data_valid is 1.
  - Otherwise: the frame is dropped, overrun is set to 1, and data_out and the flags are unchanged.
  - In both cases rx_done pulses for 1 clock.
- After commit: go to IDLE if ferr=0; otherwise go to WAIT_HIGH, which stays until the synchronised line is 1, then goes to IDLE. This prevents a break condition from retriggering a start.
- Handshake: data_valid=1 with data_ready=1 clears data_valid on the next edge, unless a commit occurs in the same cycle.
- data_out and the error flags hold their values while data_valid=1.
- overrun clears only on reset.
- enable=0 in any state other than IDLE: return to IDLE on the next clock. The partial frame is discarded, with no rx_done and no overrun. data_valid and data_out are unaffected.
- reset asserted mid-frame: return immediately to the reset state. Any held word is lost.
- Bit timing from the synchronised start edge: mid-start at OVERSAMPLE/2 ticks; each subsequent sample OVERSAMPLE ticks later. For 8N1 at 16x, the stop sample falls at tick 8 + 16*9 = 152.

Test Plan:
- 8N1, 16x: send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) with data_ready=0 -> at tick 152, rx_done pulses once, data_out=0xA5, data_valid=1, both error flags 0, busy drops to 0.
- Glitch rejection: drive bit_rx low for 5 ticks, then high -> FSM returns to IDLE; no rx_done, data_valid stays 0.
- PARITY=2 (even), send 0x03 with parity bit 1 -> data_out=0x03, parity_error=1. Resend with parity bit 0 -> parity_error=0.
- Framing and break: send 0x55 with the stop bit low, then hold the line low for 40 ticks -> framing_error=1, a single rx_done, FSM held in WAIT_HIGH, no second frame received.
- Overrun: receive 0x11 and leave it unconsumed, then receive 0x22 -> data_out stays 0x11, overrun=1. Then data_ready=1 -> data_valid=0 next clock, overrun stays 1.
- Simultaneous events: assert data_ready in exactly the commit cycle of 0x7E while 0x11 is held -> data_out=0x7E, data_valid stays 1, overrun=0. Separately, assert reset and then enable=0 mid-DATA -> all outputs 0 and FSM in IDLE, with no rx_done.
